// File: rtl/t01_vga_timing_pkg.sv
// Shared timing defaults, colour type and small helpers for the VGA timing block.
package t01_vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;
    localparam bit DEF_SYNC_POL = 1'b0;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [2:0] color_t;

    localparam color_t BLACK = 3'b000;
    localparam color_t RED   = 3'b100;
    localparam color_t WHITE = 3'b111;

    // True when cnt lies in [lo, lo+len); bounds always fit in 10 bits.
    function automatic logic in_window(logic [9:0] cnt, int lo, int len);
        return (cnt >= 10'(lo)) && (cnt < 10'(lo + len));
    endfunction

endpackage

// File: rtl/t01_vga_timing_if.sv
// Raster bus between the timing generator and its consumers.
interface t01_vga_timing_if
    import t01_vga_pkg::*;
    ;

    logic       en;
    color_t     color_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_tick;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    logic       active;
    color_t     rgb;

    modport master (
        input  en, color_in,
        output x, y, pix_tick, frame_start, hsync, vsync, active, rgb
    );

    modport slave (
        output en, color_in,
        input  x, y, pix_tick, frame_start, hsync, vsync, active, rgb
    );

endinterface

// File: rtl/t01_vga_timing_wrap_counter.sv
// 10-bit up-counter that wraps to zero after MAX; wrap flags the wrapping increment.
module t01_vga_wrap_counter #(
    parameter logic [9:0] MAX = 10'd799
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [9:0] cnt,
    output logic       wrap
);

    assign wrap = inc && (cnt == MAX);

    // Count on inc, returning to zero at MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == MAX) ? '0 : cnt + 10'd1;
        end
    end

endmodule

// File: rtl/t01_vga_timing.sv
// VGA raster timing: pixel divider, h/v counters and a one-pixel-late sync/colour stage.
module t01_vga_timing
    import t01_vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             rst,
    t01_vga_timing_if.master bus
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_active;
    logic             r_hsync;
    logic             r_vsync;
    color_t           r_rgb;

    logic             w_pix_tick;
    logic [9:0]       w_h_cnt;
    logic [9:0]       w_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_act_raw;
    logic             w_hs_raw;
    logic             w_vs_raw;

    // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so every enabled clock ticks.
    assign w_pix_tick = bus.en && (r_div_cnt == DIV_LAST);

    // Clock divider producing the pixel rate; frozen while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (bus.en) begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    t01_vga_wrap_counter #(.MAX(H_LAST)) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_pix_tick),
        .cnt  (w_h_cnt),
        .wrap (w_h_wrap)
    );

    t01_vga_wrap_counter #(.MAX(V_LAST)) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_h_wrap),
        .cnt  (w_v_cnt),
        .wrap (w_v_wrap)
    );

    assign w_act_raw = (w_h_cnt < H_ACT) && (w_v_cnt < V_ACT);
    assign w_hs_raw  = in_window(w_h_cnt, H_ACTIVE + H_FP, H_SYNC);
    assign w_vs_raw  = in_window(w_v_cnt, V_ACTIVE + V_FP, V_SYNC);

    // Output stage: everything here is one pixel behind x/y, keeping sync and colour aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_hsync  <= ~SYNC_POL;
            r_vsync  <= ~SYNC_POL;
            r_rgb    <= BLACK;
        end else if (w_pix_tick) begin
            r_active <= w_act_raw;
            r_hsync  <= w_hs_raw ? SYNC_POL : ~SYNC_POL;
            r_vsync  <= w_vs_raw ? SYNC_POL : ~SYNC_POL;
            r_rgb    <= w_act_raw ? bus.color_in : BLACK;
        end
    end

    assign bus.x           = w_h_cnt;
    assign bus.y           = w_v_cnt;
    assign bus.pix_tick    = w_pix_tick;
    assign bus.frame_start = w_v_wrap;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.active      = r_active;
    assign bus.rgb         = r_rgb;

endmodule
